// File: rtl/clock_tree_pkg.sv
// clock_tree_pkg
// Shared types, handshake constants and helpers for the clock tree leaf logic.
//   clk_leaf_state_e : leaf requester FSM encoding (OFF, WAKE, ON, SLEEP)
//   REQ_* / CLK_*    : levels of the child-side request and clock-valid signals
//   cnt_w(max)       : width of a saturating counter that must hold 0..max
package clock_tree_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        WAKE  = 3'd1,
        ON    = 3'd2,
        SLEEP = 3'd3
    } clk_leaf_state_e;

    // Request level presented to the leaf tie.
    localparam logic REQ_ASSERT    = 1'b1;
    localparam logic REQ_RELEASE   = 1'b0;

    // clock_valid level presented to local logic.
    localparam logic CLK_USABLE    = 1'b1;
    localparam logic CLK_UNUSABLE  = 1'b0;

    // A counter holding 0..max needs $clog2(max+1) bits; never less than one.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/clock_sat_counter.sv
// clock_sat_counter
// Up-counter that stops at MAX and never wraps. clear has priority over inc.
// Ports:
//   clock, async_reset : control clock, asynchronous active-high reset
//   clear              : return the count to zero
//   inc                : advance the count by one unless already at MAX
//   value              : current count
//   sat                : count equals MAX
module clock_sat_counter
    import clock_tree_pkg::*;
#(
    parameter int MAX = 1,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clock,
    input  logic         async_reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         sat
);

    assign sat = (value == W'(MAX));

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && !sat) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/clock_leaf_requester.sv
// clock_leaf_requester
// Leaf controller of the clock division tree: converts a local work-pending
// level into the request/ready handshake of the last tree stage, tells local
// logic when the routed clock is usable, and drops the request after an idle
// period once a minimum on-time has elapsed.
// Ports:
//   clock, async_reset : control clock, asynchronous active-high reset
//   activity_in        : local work pending (level)
//   parent_ready       : routed clock running and stable
//   parent_silent      : routed clock fully stopped
//   parent_starting    : parent is enabling the clock
//   parent_stopping    : parent is disabling the clock
//   clear_timeout      : pulse clearing wake_timeout (ignored while in WAKE)
//   parent_request     : clock request to the leaf tie
//   clock_valid        : local logic may use the routed clock
//   busy               : FSM is not in OFF
//   wake_timeout       : sticky, wake request unanswered for TIMEOUT_CYCLES
//   state_out          : encoded FSM state for debug
// All outputs are registered.
module clock_leaf_requester
    import clock_tree_pkg::*;
#(
    parameter int IDLE_CYCLES    = 64,
    parameter int MIN_ON_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       async_reset,
    input  logic       activity_in,
    input  logic       parent_ready,
    input  logic       parent_silent,
    input  logic       parent_starting,
    input  logic       parent_stopping,
    input  logic       clear_timeout,
    output logic       parent_request,
    output logic       clock_valid,
    output logic       busy,
    output logic       wake_timeout,
    output logic [2:0] state_out
);

    localparam int IDLE_W = cnt_w(IDLE_CYCLES);
    localparam int MIN_W  = cnt_w(MIN_ON_CYCLES);
    localparam int WAKE_W = cnt_w(TIMEOUT_CYCLES);

    clk_leaf_state_e state_reg, state_next;
    logic            pend_reg, pend_next;

    logic            request_next;
    logic            valid_next;
    logic            busy_next;
    logic [2:0]      state_out_next;

    logic [IDLE_W-1:0] idle_val;
    logic [MIN_W-1:0]  min_val;
    logic [WAKE_W-1:0] wake_val;
    logic              idle_sat, min_sat, wake_sat;
    logic              idle_hit, min_hit, wake_hit;
    logic              timeout_set;

    // ------------------------------------------------------------------
    // Counters. Each is held at zero outside the state it measures, so it
    // restarts on every entry (including ON -> WAKE after a ready loss).
    // ------------------------------------------------------------------
    clock_sat_counter #(.MAX(IDLE_CYCLES)) u_idle_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .clear       ((state_reg != ON) || activity_in),
        .inc         (state_reg == ON),
        .value       (idle_val),
        .sat         (idle_sat)
    );

    clock_sat_counter #(.MAX(MIN_ON_CYCLES)) u_min_on_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .clear       (state_reg != ON),
        .inc         (state_reg == ON),
        .value       (min_val),
        .sat         (min_sat)
    );

    clock_sat_counter #(.MAX(TIMEOUT_CYCLES)) u_wake_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .clear       (state_reg != WAKE),
        .inc         (state_reg == WAKE),
        .value       (wake_val),
        .sat         (wake_sat)
    );

    // "hit" means the count reaches its limit at the coming edge, i.e. the
    // current cycle is the one that completes the interval. This makes the
    // release land exactly IDLE_CYCLES edges after the last active edge.
    assign idle_hit = idle_sat || ((int'(idle_val) + 1) >= IDLE_CYCLES);
    assign min_hit  = min_sat  || ((int'(min_val)  + 1) >= MIN_ON_CYCLES);
    assign wake_hit = wake_sat || ((int'(wake_val) + 1) >= TIMEOUT_CYCLES);

    assign timeout_set = (state_reg == WAKE) && wake_hit;

    // ------------------------------------------------------------------
    // State register (also registers outputs, pend and the timeout flag)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_reg      <= OFF;
            pend_reg       <= 1'b0;
            parent_request <= REQ_RELEASE;
            clock_valid    <= CLK_UNUSABLE;
            busy           <= 1'b0;
            state_out      <= 3'd0;
            wake_timeout   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_reg       <= pend_next;
            parent_request <= request_next;
            clock_valid    <= valid_next;
            busy           <= busy_next;
            state_out      <= state_out_next;
            // While waking, a clear pulse cannot hide an unanswered request.
            if (state_reg == WAKE) begin
                if (timeout_set) begin
                    wake_timeout <= 1'b1;
                end
            end else if (clear_timeout) begin
                wake_timeout <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OFF: begin
                // Only request once the tree has fully stopped.
                if ((activity_in || pend_reg) && parent_silent) begin
                    state_next = WAKE;
                end
            end
            WAKE: begin
                if (parent_ready && !parent_starting) begin
                    state_next = ON;
                end
            end
            ON: begin
                // Ready loss outranks idle expiry; activity blocks release.
                if (!parent_ready) begin
                    state_next = WAKE;
                end else if (idle_hit && min_hit && !activity_in) begin
                    state_next = SLEEP;
                end
            end
            SLEEP: begin
                if (parent_silent && !parent_stopping) begin
                    state_next = OFF;
                end
            end
            default: state_next = OFF;
        endcase

        // Remember work that arrives while the tree is shutting down.
        pend_next = pend_reg;
        if ((state_next == WAKE) && (state_reg != WAKE)) begin
            pend_next = 1'b0;
        end else if ((state_reg == SLEEP) && activity_in) begin
            pend_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic, decoded from the next state so outputs are registered
    // ------------------------------------------------------------------
    always_comb begin
        request_next   = REQ_RELEASE;
        valid_next     = CLK_UNUSABLE;
        busy_next      = (state_next != OFF);
        state_out_next = state_next;
        case (state_next)
            WAKE: request_next = REQ_ASSERT;
            ON: begin
                request_next = REQ_ASSERT;
                valid_next   = CLK_USABLE;
            end
            default: begin
                request_next = REQ_RELEASE;
                valid_next   = CLK_UNUSABLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_leaf_requester.sv
module tb_clock_leaf_requester;

    logic       clock = 1'b0;
    logic       async_reset;
    logic       activity_in, parent_ready, parent_silent;
    logic       parent_starting, parent_stopping, clear_timeout;
    logic       req_a, valid_a, busy_a, tmo_a;
    logic [2:0] st_a;
    logic       req_b, valid_b, busy_b, tmo_b;
    logic [2:0] st_b;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    // Default parameters: IDLE 64, MIN_ON 16, TIMEOUT 1024.
    clock_leaf_requester u_dut (
        .clock           (clock),
        .async_reset     (async_reset),
        .activity_in     (activity_in),
        .parent_ready    (parent_ready),
        .parent_silent   (parent_silent),
        .parent_starting (parent_starting),
        .parent_stopping (parent_stopping),
        .clear_timeout   (clear_timeout),
        .parent_request  (req_a),
        .clock_valid     (valid_a),
        .busy            (busy_a),
        .wake_timeout    (tmo_a),
        .state_out       (st_a)
    );

    // Same stimulus, long minimum on-time.
    clock_leaf_requester #(.MIN_ON_CYCLES(100)) u_dut_minon (
        .clock           (clock),
        .async_reset     (async_reset),
        .activity_in     (activity_in),
        .parent_ready    (parent_ready),
        .parent_silent   (parent_silent),
        .parent_starting (parent_starting),
        .parent_stopping (parent_stopping),
        .clear_timeout   (clear_timeout),
        .parent_request  (req_b),
        .clock_valid     (valid_b),
        .busy            (busy_b),
        .wake_timeout    (tmo_b),
        .state_out       (st_b)
    );

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        async_reset = 1'b1;
        activity_in = 1'b0; parent_ready = 1'b0; parent_silent = 1'b1;
        parent_starting = 1'b0; parent_stopping = 1'b0; clear_timeout = 1'b0;
        tick(2);
        checks++; if ({req_a, valid_a, busy_a, tmo_a, st_a} !== 7'd0) $display("FAIL reset_outputs: got %b want 0000000", {req_a, valid_a, busy_a, tmo_a, st_a}); else passes++;
        checks++; if ({req_b, valid_b, busy_b, tmo_b, st_b} !== 7'd0) $display("FAIL reset_outputs_minon: got %b want 0000000", {req_b, valid_b, busy_b, tmo_b, st_b}); else passes++;
        async_reset = 1'b0;
        tick(1);
        checks++; if (st_a !== 3'd0) $display("FAIL idle_off: state got %0d want 0", st_a); else passes++;
        $display("reset: state=%0d request=%0b", st_a, req_a);
    endtask

    task automatic test_wake_on();
        activity_in = 1'b1;
        tick(1);
        checks++; if (req_a !== 1'b1) $display("FAIL wake_request: got %0b want 1", req_a); else passes++;
        checks++; if (st_a !== 3'd1 || valid_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL wake_state: state=%0d valid=%0b busy=%0b want 1/0/1", st_a, valid_a, busy_a); else passes++;
        parent_silent = 1'b0; parent_starting = 1'b1;
        tick(4);
        checks++; if (st_a !== 3'd1 || valid_a !== 1'b0) $display("FAIL wake_hold: state=%0d valid=%0b want 1/0", st_a, valid_a); else passes++;
        parent_ready = 1'b1; parent_starting = 1'b0;
        tick(1);
        checks++; if (valid_a !== 1'b1 || st_a !== 3'd2) $display("FAIL on_valid: valid=%0b state=%0d want 1/2", valid_a, st_a); else passes++;
        $display("wake_on: state=%0d valid=%0b timeout=%0b", st_a, valid_a, tmo_a);
    endtask

    // Entered ON at edge E; activity stays high through E+3, then idle.
    task automatic test_release();
        tick(3);
        activity_in = 1'b0;
        tick(63);
        checks++; if (req_a !== 1'b1 || st_a !== 3'd2) $display("FAIL release_early: request=%0b state=%0d want 1/2", req_a, st_a); else passes++;
        tick(1);
        checks++; if (req_a !== 1'b0 || valid_a !== 1'b0 || st_a !== 3'd3 || busy_a !== 1'b1) $display("FAIL release_at_64: request=%0b valid=%0b state=%0d busy=%0b want 0/0/3/1", req_a, valid_a, st_a, busy_a); else passes++;
        checks++; if (st_b !== 3'd2 || req_b !== 1'b1) $display("FAIL minon_hold_67: state=%0d request=%0b want 2/1", st_b, req_b); else passes++;
        tick(32);
        checks++; if (st_b !== 3'd2) $display("FAIL minon_hold_99: state=%0d want 2", st_b); else passes++;
        tick(1);
        checks++; if (st_b !== 3'd3 || req_b !== 1'b0) $display("FAIL minon_release_100: state=%0d request=%0b want 3/0", st_b, req_b); else passes++;
        $display("release: state=%0d minon_state=%0d", st_a, st_b);
    endtask

    task automatic test_sleep_pend();
        parent_ready = 1'b0; parent_stopping = 1'b1;
        activity_in = 1'b1;
        tick(1);
        activity_in = 1'b0;
        checks++; if (req_a !== 1'b0 || st_a !== 3'd3) $display("FAIL sleep_no_request: request=%0b state=%0d want 0/3", req_a, st_a); else passes++;
        tick(2);
        checks++; if (req_a !== 1'b0 || st_a !== 3'd3) $display("FAIL sleep_wait_silent: request=%0b state=%0d want 0/3", req_a, st_a); else passes++;
        parent_silent = 1'b1; parent_stopping = 1'b0;
        tick(1);
        checks++; if (st_a !== 3'd0 || busy_a !== 1'b0 || req_a !== 1'b0) $display("FAIL sleep_to_off: state=%0d busy=%0b request=%0b want 0/0/0", st_a, busy_a, req_a); else passes++;
        tick(1);
        checks++; if (st_a !== 3'd1 || req_a !== 1'b1) $display("FAIL pend_wake: state=%0d request=%0b want 1/1", st_a, req_a); else passes++;
        $display("sleep_pend: state=%0d request=%0b", st_a, req_a);
    endtask

    // WAKE entered at edge W; flag rises at W+1024.
    task automatic test_timeout();
        tick(1023);
        checks++; if (tmo_a !== 1'b0) $display("FAIL timeout_1023: got %0b want 0", tmo_a); else passes++;
        tick(1);
        checks++; if (tmo_a !== 1'b1 || req_a !== 1'b1 || st_a !== 3'd1) $display("FAIL timeout_1024: timeout=%0b request=%0b state=%0d want 1/1/1", tmo_a, req_a, st_a); else passes++;
        clear_timeout = 1'b1;
        tick(1);
        clear_timeout = 1'b0;
        checks++; if (tmo_a !== 1'b1) $display("FAIL clear_in_wake: got %0b want 1", tmo_a); else passes++;
        parent_ready = 1'b1; parent_silent = 1'b0;
        tick(1);
        checks++; if (st_a !== 3'd2 || tmo_a !== 1'b1) $display("FAIL timeout_on: state=%0d timeout=%0b want 2/1", st_a, tmo_a); else passes++;
        clear_timeout = 1'b1;
        tick(1);
        clear_timeout = 1'b0;
        checks++; if (tmo_a !== 1'b0) $display("FAIL clear_in_on: got %0b want 0", tmo_a); else passes++;
        $display("timeout: state=%0d timeout=%0b", st_a, tmo_a);
    endtask

    task automatic test_ready_loss();
        activity_in = 1'b1; parent_ready = 1'b0;
        tick(1);
        checks++; if (valid_a !== 1'b0 || st_a !== 3'd1 || req_a !== 1'b1) $display("FAIL ready_loss: valid=%0b state=%0d request=%0b want 0/1/1", valid_a, st_a, req_a); else passes++;
        parent_ready = 1'b1;
        tick(1);
        checks++; if (st_a !== 3'd2 || tmo_a !== 1'b0) $display("FAIL ready_back: state=%0d timeout=%0b want 2/0", st_a, tmo_a); else passes++;
        // Ready loss on the same edge the idle interval expires.
        activity_in = 1'b0;
        tick(63);
        parent_ready = 1'b0;
        tick(1);
        checks++; if (st_a !== 3'd1 || req_a !== 1'b1 || valid_a !== 1'b0) $display("FAIL loss_vs_idle: state=%0d request=%0b valid=%0b want 1/1/0", st_a, req_a, valid_a); else passes++;
        $display("ready_loss: state=%0d request=%0b", st_a, req_a);
    endtask

    task automatic test_activity_vs_idle();
        parent_ready = 1'b1;
        tick(1);
        tick(63);
        activity_in = 1'b1;
        tick(1);
        activity_in = 1'b0;
        checks++; if (st_a !== 3'd2 || req_a !== 1'b1) $display("FAIL activity_wins: state=%0d request=%0b want 2/1", st_a, req_a); else passes++;
        tick(63);
        checks++; if (st_a !== 3'd2) $display("FAIL rearm_hold: state=%0d want 2", st_a); else passes++;
        tick(1);
        checks++; if (st_a !== 3'd3 || st_b !== 3'd3) $display("FAIL rearm_release: state=%0d minon_state=%0d want 3/3", st_a, st_b); else passes++;
        $display("activity_vs_idle: state=%0d", st_a);
    endtask

    task automatic test_async_reset();
        parent_silent = 1'b1; activity_in = 1'b1;
        tick(3);
        checks++; if (st_a !== 3'd2 || valid_a !== 1'b1) $display("FAIL pre_reset_on: state=%0d valid=%0b want 2/1", st_a, valid_a); else passes++;
        #2 async_reset = 1'b1;
        #1;
        checks++; if ({req_a, valid_a, busy_a, tmo_a, st_a} !== 7'd0) $display("FAIL async_reset_now: got %b want 0000000", {req_a, valid_a, busy_a, tmo_a, st_a}); else passes++;
        async_reset = 1'b0; activity_in = 1'b0;
        tick(1);
        checks++; if (st_a !== 3'd0 || req_a !== 1'b0) $display("FAIL after_reset_off: state=%0d request=%0b want 0/0", st_a, req_a); else passes++;
        $display("async_reset: state=%0d request=%0b", st_a, req_a);
    endtask

    initial begin
        test_reset();
        test_wake_on();
        test_release();
        test_sleep_pend();
        test_timeout();
        test_ready_loss();
        test_activity_vs_idle();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
